// File: rtl/hfsm_pkg.sv
// ---------------------------------------------------------------------------
// hfsm_pkg
// Shared definitions for the multi-image averaging sequencer:
//   - seq_state_e    : sequencer FSM states (IDLE, RUN, DONE)
//   - DEF_*          : default image geometry and image count
//   - pix_aw_calc()  : smallest address width that covers a given pixel count
// ---------------------------------------------------------------------------
package hfsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int DEF_HIM_LEN           = 520;
    localparam int DEF_HIM_WID           = 520;
    localparam int DEF_LOG2_NO_OF_IMAGES = 4;
    localparam int DEF_NO_OF_IMAGES      = 16;

    // Minimum width w (at least 1) such that 2**w >= n_pix.
    function automatic int pix_aw_calc(input int n_pix);
        int w;
        w = 1;
        while ((w < 31) && ((1 << w) < n_pix)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : hfsm_pkg

// File: rtl/hraster_counter.sv
// ---------------------------------------------------------------------------
// hraster_counter
// Raster position tracker for one image: column, row and linear pixel address.
// Advances by one pixel on each step; wraps to (0,0) after the last pixel.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (clears all counters)
//   step     in   pixel accepted this cycle: advance position
//   clear    in   synchronous return to (0,0), takes priority over step
//   col      out  current column
//   row      out  current row
//   pix_addr out  current linear address (row*HIM_WID + col)
//   sof      out  position is (0,0)         (unqualified)
//   eof      out  position is the last pixel (unqualified)
// ---------------------------------------------------------------------------
module hraster_counter
    import hfsm_pkg::*;
#(
    parameter int HIM_LEN = DEF_HIM_LEN,
    parameter int HIM_WID = DEF_HIM_WID,
    parameter int PIX_AW  = pix_aw_calc(DEF_HIM_LEN * DEF_HIM_WID)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              clear,
    output logic [15:0]       col,
    output logic [15:0]       row,
    output logic [PIX_AW-1:0] pix_addr,
    output logic              sof,
    output logic              eof
);

    localparam logic [15:0]       COL_LAST = 16'(HIM_WID - 1);
    localparam logic [15:0]       ROW_LAST = 16'(HIM_LEN - 1);
    localparam logic [15:0]       CNT_ONE  = 16'd1;
    localparam logic [PIX_AW-1:0] ADDR_ONE = PIX_AW'(1);

    logic [15:0]       col_reg,  col_next;
    logic [15:0]       row_reg,  row_next;
    logic [PIX_AW-1:0] addr_reg, addr_next;
    logic              col_last;

    assign col_last = (col_reg == COL_LAST);
    assign eof      = col_last && (row_reg == ROW_LAST);
    assign sof      = (col_reg == 16'd0) && (row_reg == 16'd0);

    always_comb begin
        col_next  = col_reg;
        row_next  = row_reg;
        addr_next = addr_reg;
        if (clear) begin
            col_next  = '0;
            row_next  = '0;
            addr_next = '0;
        end else if (step) begin
            if (eof) begin
                // Image complete: next accepted pixel starts a fresh image.
                col_next  = '0;
                row_next  = '0;
                addr_next = '0;
            end else if (col_last) begin
                col_next  = '0;
                row_next  = row_reg + CNT_ONE;
                addr_next = addr_reg + ADDR_ONE;
            end else begin
                col_next  = col_reg + CNT_ONE;
                addr_next = addr_reg + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg  <= '0;
            row_reg  <= '0;
            addr_reg <= '0;
        end else begin
            col_reg  <= col_next;
            row_reg  <= row_next;
            addr_reg <= addr_next;
        end
    end

    assign col      = col_reg;
    assign row      = row_reg;
    assign pix_addr = addr_reg;

endmodule : hraster_counter

// File: rtl/hframe_sequencer.sv
// ---------------------------------------------------------------------------
// hframe_sequencer
// Handshake-driven sequencer for the multi-image averaging pipeline. Counts
// accepted source pixels through NO_OF_IMAGES images and drives the
// accumulator controls (first-image write, accumulate, last-image emit).
// During the last image, acceptance is gated by downstream readiness.
//
// Ports:
//   hclk      in   clock
//   hres      in   asynchronous active-low reset
//   start     in   run request, only looked at in IDLE
//   abort     in   abandon the current run (RUN only)
//   in_valid  in   source pixel valid
//   in_ready  out  sequencer can accept a pixel (combinational)
//   out_ready in   downstream can take an averaged pixel
//   acc_en    out  pixel accepted this cycle
//   acc_first out  current image is image 0 (write, do not add)
//   acc_last  out  current image is the last one (emit average)
//   pix_addr  out  linear address of the pixel being accepted
//   col, row  out  raster position of the pixel being accepted
//   hstate    out  current image index
//   sof, eof  out  accepted pixel is first / last pixel of an image
//   busy      out  sequencer is in RUN
//   done      out  one-cycle pulse after the final pixel of a run
// ---------------------------------------------------------------------------
module hframe_sequencer
    import hfsm_pkg::*;
#(
    parameter int HIM_LEN           = DEF_HIM_LEN,
    parameter int HIM_WID           = DEF_HIM_WID,
    parameter int LOG2_NO_OF_IMAGES = DEF_LOG2_NO_OF_IMAGES,
    parameter int NO_OF_IMAGES      = DEF_NO_OF_IMAGES,
    parameter int PIX_AW            = pix_aw_calc(HIM_LEN * HIM_WID)
) (
    input  logic                         hclk,
    input  logic                         hres,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         out_ready,
    output logic                         acc_en,
    output logic                         acc_first,
    output logic                         acc_last,
    output logic [PIX_AW-1:0]            pix_addr,
    output logic [15:0]                  col,
    output logic [15:0]                  row,
    output logic [LOG2_NO_OF_IMAGES-1:0] hstate,
    output logic                         sof,
    output logic                         eof,
    output logic                         busy,
    output logic                         done
);

    localparam logic [LOG2_NO_OF_IMAGES-1:0] IMG_LAST = LOG2_NO_OF_IMAGES'(NO_OF_IMAGES - 1);
    localparam logic [LOG2_NO_OF_IMAGES-1:0] IMG_ONE  = LOG2_NO_OF_IMAGES'(1);

    seq_state_e                   state_reg, state_next;
    logic [LOG2_NO_OF_IMAGES-1:0] hstate_reg, hstate_next;

    logic is_run;
    logic raster_clear;
    logic raster_sof;
    logic raster_eof;

    assign is_run = (state_reg == RUN);

    // Image-role flags are only meaningful while a run is in progress.
    assign acc_first = is_run && (hstate_reg == '0);
    assign acc_last  = is_run && (hstate_reg == IMG_LAST);

    // Backpressure only applies in the last image, where each accepted pixel
    // produces an averaged output that downstream must be able to take.
    assign in_ready = is_run && !abort && (!acc_last || out_ready);
    assign acc_en   = in_valid && in_ready;

    assign sof    = acc_en && raster_sof;
    assign eof    = acc_en && raster_eof;
    assign hstate = hstate_reg;

    hraster_counter #(
        .HIM_LEN (HIM_LEN),
        .HIM_WID (HIM_WID),
        .PIX_AW  (PIX_AW)
    ) u_raster (
        .clk      (hclk),
        .rst_n    (hres),
        .step     (acc_en),
        .clear    (raster_clear),
        .col      (col),
        .row      (row),
        .pix_addr (pix_addr),
        .sof      (raster_sof),
        .eof      (raster_eof)
    );

    always_comb begin
        state_next   = state_reg;
        hstate_next  = hstate_reg;
        raster_clear = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            IDLE: begin
                // Counters are guaranteed zero here: runs end either on the
                // final eof wrap or via abort, both of which clear them.
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next   = IDLE;
                    hstate_next  = '0;
                    raster_clear = 1'b1;
                end else if (acc_en && raster_eof) begin
                    if (hstate_reg == IMG_LAST) begin
                        hstate_next = '0;
                        state_next  = DONE;
                    end else begin
                        hstate_next = hstate_reg + IMG_ONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hres) begin
        if (!hres) begin
            state_reg  <= IDLE;
            hstate_reg <= '0;
        end else begin
            state_reg  <= state_next;
            hstate_reg <= hstate_next;
        end
    end

endmodule : hframe_sequencer

// File: tb/tb_hframe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hframe_sequencer
// Directed bench for hframe_sequencer with a 3x4 image and 2 images per run.
// Inputs change on the falling edge; outputs are checked 1 ns later, well
// before the next rising edge.
// ---------------------------------------------------------------------------
module tb_hframe_sequencer;

    localparam int HIM_LEN  = 3;
    localparam int HIM_WID  = 4;
    localparam int NIMG     = 2;
    localparam int LOG2_N   = 4;
    localparam int PAW      = 4;
    localparam int NPIX     = HIM_LEN * HIM_WID;

    logic              hclk;
    logic              hres;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic              out_ready;
    logic              acc_en;
    logic              acc_first;
    logic              acc_last;
    logic [PAW-1:0]    pix_addr;
    logic [15:0]       col;
    logic [15:0]       row;
    logic [LOG2_N-1:0] hstate;
    logic              sof;
    logic              eof;
    logic              busy;
    logic              done;

    int checks;
    int passes;
    int fails;

    hframe_sequencer #(
        .HIM_LEN           (HIM_LEN),
        .HIM_WID           (HIM_WID),
        .LOG2_NO_OF_IMAGES (LOG2_N),
        .NO_OF_IMAGES      (NIMG),
        .PIX_AW            (PAW)
    ) dut (
        .hclk      (hclk),
        .hres      (hres),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .acc_en    (acc_en),
        .acc_first (acc_first),
        .acc_last  (acc_last),
        .pix_addr  (pix_addr),
        .col       (col),
        .row       (row),
        .hstate    (hstate),
        .sof       (sof),
        .eof       (eof),
        .busy      (busy),
        .done      (done)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect global pixel k (0..NPIX*NIMG-1) of the run to be accepted now.
    task automatic expect_pix(input int k);
        int p;
        int img;
        p   = k % NPIX;
        img = k / NPIX;
        $display("t=%0t accept k=%0d img=%0d addr=%0d col=%0d row=%0d sof=%0b eof=%0b",
                 $time, k, hstate, pix_addr, col, row, sof, eof);
        chk("acc_en",    32'(acc_en),    32'd1);
        chk("pix_addr",  32'(pix_addr),  32'(p));
        chk("col",       32'(col),       32'(p % HIM_WID));
        chk("row",       32'(row),       32'(p / HIM_WID));
        chk("hstate",    32'(hstate),    32'(img));
        chk("sof",       32'(sof),       32'(p == 0));
        chk("eof",       32'(eof),       32'(p == NPIX - 1));
        chk("acc_first", 32'(acc_first), 32'(img == 0));
        chk("acc_last",  32'(acc_last),  32'(img == NIMG - 1));
        chk("busy_run",  32'(busy),      32'd1);
        chk("done_run",  32'(done),      32'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        passes = 0;
        fails  = 0;
        hres      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // ---- reset state ----
        @(negedge hclk); #1;
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_done",     32'(done),      32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd0);
        chk("rst_pix_addr", 32'(pix_addr),  32'd0);
        chk("rst_col",      32'(col),       32'd0);
        chk("rst_row",      32'(row),       32'd0);
        chk("rst_hstate",   32'(hstate),    32'd0);
        chk("rst_first",    32'(acc_first), 32'd0);
        @(negedge hclk); hres = 1'b1; #1;
        chk("idle_busy",    32'(busy),      32'd0);

        // ---- full run, continuous valid/ready ----
        @(negedge hclk); start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_acc_en",   32'(acc_en),   32'd0);
        for (int k = 0; k < NPIX * NIMG; k++) begin
            @(negedge hclk); start = 1'b0; #1;
            expect_pix(k);
        end
        @(negedge hclk); in_valid = 1'b0; #1;
        chk("run1_done",   32'(done),   32'd1);
        chk("run1_busy",   32'(busy),   32'd0);
        chk("run1_acc_en", 32'(acc_en), 32'd0);
        @(negedge hclk); #1;
        chk("run1_done_gone", 32'(done), 32'd0);
        chk("run1_idle",      32'(busy), 32'd0);

        // ---- in_valid toggling: addresses only move on accepts ----
        @(negedge hclk); start = 1'b1; #1;
        n = 0;
        for (int c = 0; c < 2 * NPIX * NIMG - 1; c++) begin
            @(negedge hclk); start = 1'b0; in_valid = (c % 2 == 0); #1;
            if (c % 2 == 0) begin
                expect_pix(n);
                n++;
            end else begin
                chk("gap_acc_en",   32'(acc_en),   32'd0);
                chk("gap_pix_addr", 32'(pix_addr), 32'(n % NPIX));
                chk("gap_hstate",   32'(hstate),   32'(n / NPIX));
            end
        end
        @(negedge hclk); in_valid = 1'b0; #1;
        chk("run2_done", 32'(done), 32'd1);

        // ---- out_ready low: no effect in image 0, stalls image 1 ----
        @(negedge hclk); start = 1'b1; in_valid = 1'b1; out_ready = 1'b0; #1;
        for (int k = 0; k < NPIX; k++) begin
            @(negedge hclk); start = 1'b0; #1;
            chk("img0_in_ready", 32'(in_ready), 32'd1);
            expect_pix(k);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge hclk); #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_acc_en",   32'(acc_en),   32'd0);
            chk("stall_pix_addr", 32'(pix_addr), 32'd0);
            chk("stall_hstate",   32'(hstate),   32'd1);
            chk("stall_acc_last", 32'(acc_last), 32'd1);
        end
        for (int k = NPIX; k < NPIX * NIMG; k++) begin
            @(negedge hclk); out_ready = 1'b1; #1;
            expect_pix(k);
        end
        @(negedge hclk); in_valid = 1'b0; #1;
        chk("run3_done", 32'(done), 32'd1);

        // ---- abort at pix_addr 7 of image 1 ----
        @(negedge hclk); start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; #1;
        for (int k = 0; k < NPIX + 7; k++) begin
            @(negedge hclk); start = 1'b0; #1;
            expect_pix(k);
        end
        @(negedge hclk); abort = 1'b1; #1;
        chk("abort_acc_en",   32'(acc_en),   32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_pix_addr", 32'(pix_addr), 32'd7);
        chk("abort_hstate",   32'(hstate),   32'd1);
        @(negedge hclk); abort = 1'b0; in_valid = 1'b0; #1;
        chk("post_abort_busy",   32'(busy),     32'd0);
        chk("post_abort_done",   32'(done),     32'd0);
        chk("post_abort_hstate", 32'(hstate),   32'd0);
        chk("post_abort_addr",   32'(pix_addr), 32'd0);
        chk("post_abort_col",    32'(col),      32'd0);
        chk("post_abort_row",    32'(row),      32'd0);
        @(negedge hclk); #1;
        chk("post_abort_done2",  32'(done),     32'd0);

        // ---- start+abort in IDLE: start wins; start then held through DONE ----
        @(negedge hclk); start = 1'b1; abort = 1'b1; in_valid = 1'b1; #1;
        chk("sa_idle_acc_en", 32'(acc_en), 32'd0);
        for (int k = 0; k < NPIX * NIMG; k++) begin
            @(negedge hclk); abort = 1'b0; #1;
            expect_pix(k);
        end
        @(negedge hclk); #1;
        chk("held_done",      32'(done),   32'd1);
        chk("held_done_busy", 32'(busy),   32'd0);
        chk("held_done_acc",  32'(acc_en), 32'd0);
        @(negedge hclk); #1;
        chk("held_idle_done", 32'(done),   32'd0);
        chk("held_idle_busy", 32'(busy),   32'd0);
        chk("held_idle_acc",  32'(acc_en), 32'd0);
        @(negedge hclk); #1;
        expect_pix(0);
        for (int k = 1; k < 6; k++) begin
            @(negedge hclk); start = 1'b0; #1;
            expect_pix(k);
        end

        // ---- asynchronous reset mid-run with acc_en active ----
        #1 hres = 1'b0;
        #1;
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_acc_en",    32'(acc_en),    32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd0);
        chk("arst_pix_addr",  32'(pix_addr),  32'd0);
        chk("arst_col",       32'(col),       32'd0);
        chk("arst_row",       32'(row),       32'd0);
        chk("arst_hstate",    32'(hstate),    32'd0);
        chk("arst_acc_first", 32'(acc_first), 32'd0);
        chk("arst_done",      32'(done),      32'd0);
        @(negedge hclk); hres = 1'b1; #1;
        chk("rel_busy",     32'(busy),     32'd0);
        chk("rel_pix_addr", 32'(pix_addr), 32'd0);
        @(negedge hclk); #1;
        chk("rel_idle_busy", 32'(busy),   32'd0);
        chk("rel_idle_acc",  32'(acc_en), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_hframe_sequencer
